// File: rtl/matrix_key_scanner.sv
// Row-scanned key matrix reader with frame-based debouncing.
// Drives one row low at a time. It collects the pressed keys seen over a full
// frame, then accepts a single key once it has been stable for DEBOUNCE frames.
module matrix_key_scanner #(
    parameter int unsigned ROWS     = 4,
    parameter int unsigned COLS     = 4,
    parameter int unsigned SCAN_DIV = 4,
    parameter int unsigned DEBOUNCE = 3,
    localparam int unsigned KW      = (ROWS * COLS > 2) ? $clog2(ROWS * COLS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [COLS-1:0] col_in,
    output logic [ROWS-1:0] row_drv,
    output logic [KW-1:0]   key,
    output logic            key_valid,
    output logic            key_rel,
    output logic            key_down,
    output logic            multi
);

    localparam int unsigned RW   = (ROWS > 2) ? $clog2(ROWS) : 1;
    localparam int unsigned DW   = $clog2(SCAN_DIV);
    localparam int unsigned CNTW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PRESS_CHK, S_HELD, S_REL_CHK} state_e;

    logic [COLS-1:0] sync1_q, sync2_q;
    logic [DW-1:0]   div_q, div_d;
    logic [RW-1:0]   row_q, row_d;
    logic [ROWS-1:0] row_drv_q, row_drv_d;
    logic [1:0]      acc_n_q, acc_n_d, fr_n_q, fr_n_d, n_v;
    logic [KW-1:0]   acc_code_q, acc_code_d, fr_code_q, fr_code_d, code_v;
    logic            eval_q, eval_d;
    logic            sample_c, last_row_c;
    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [KW-1:0]   cand_q, cand_d, key_q, key_d;
    logic            key_valid_q, key_valid_d, key_rel_q, key_rel_d;
    logic            key_down_q, key_down_d, multi_q, multi_d;

    assign sample_c   = (div_q == DW'(SCAN_DIV - 1));
    assign last_row_c = (row_q == RW'(ROWS - 1));

    // Dwell counter and row sequencing; row_drv is one-cold on the next row index
    always_comb begin
        div_d = sample_c ? '0 : div_q + DW'(1);
        row_d = row_q;
        if (sample_c) begin
            row_d = last_row_c ? '0 : row_q + RW'(1);
        end
        row_drv_d = ~(ROWS'(1) << row_d);
    end

    // Frame accumulator: count low columns (saturating at 2) and remember the first code
    always_comb begin
        n_v    = acc_n_q;
        code_v = acc_code_q;
        for (int unsigned c = 0; c < COLS; c++) begin
            if (!sync2_q[c]) begin
                if (n_v == 2'd0) begin
                    code_v = KW'(32'(row_q) * COLS + c);
                end
                if (n_v != 2'd2) begin
                    n_v = n_v + 2'd1;
                end
            end
        end
        acc_n_d    = acc_n_q;
        acc_code_d = acc_code_q;
        fr_n_d     = fr_n_q;
        fr_code_d  = fr_code_q;
        eval_d     = 1'b0;
        if (sample_c) begin
            if (last_row_c) begin
                fr_n_d     = n_v;
                fr_code_d  = code_v;
                acc_n_d    = 2'd0;
                acc_code_d = '0;
                eval_d     = 1'b1;
            end else begin
                acc_n_d    = n_v;
                acc_code_d = code_v;
            end
        end
    end

    // Debounce FSM, stepped once per completed frame
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        key_rel_d   = 1'b0;
        key_down_d  = key_down_q;
        multi_d     = multi_q;
        cnt_inc     = (cnt_q == CNTW'(DEBOUNCE)) ? cnt_q : cnt_q + CNTW'(1);
        if (eval_q) begin
            multi_d = (fr_n_q == 2'd2);
            case (state_q)
                S_IDLE: begin
                    if (fr_n_q == 2'd1) begin
                        cand_d = fr_code_q;
                        if (DEBOUNCE == 1) begin
                            state_d     = S_HELD;
                            cnt_d       = CNTW'(DEBOUNCE);
                            key_d       = fr_code_q;
                            key_valid_d = 1'b1;
                            key_down_d  = 1'b1;
                        end else begin
                            state_d = S_PRESS_CHK;
                            cnt_d   = CNTW'(1);
                        end
                    end
                end
                S_PRESS_CHK: begin
                    if (fr_n_q == 2'd1) begin
                        if (fr_code_q == cand_q) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc == CNTW'(DEBOUNCE)) begin
                                state_d     = S_HELD;
                                key_d       = cand_q;
                                key_valid_d = 1'b1;
                                key_down_d  = 1'b1;
                            end
                        end else begin
                            cand_d = fr_code_q;
                            cnt_d  = CNTW'(1);
                        end
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
                S_HELD: begin
                    if (fr_n_q == 2'd0) begin
                        if (DEBOUNCE == 1) begin
                            state_d    = S_IDLE;
                            cnt_d      = '0;
                            key_rel_d  = 1'b1;
                            key_down_d = 1'b0;
                        end else begin
                            state_d = S_REL_CHK;
                            cnt_d   = CNTW'(1);
                        end
                    end
                end
                default: begin
                    if (fr_n_q == 2'd0) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNTW'(DEBOUNCE)) begin
                            state_d    = S_IDLE;
                            cnt_d      = '0;
                            key_rel_d  = 1'b1;
                            key_down_d = 1'b0;
                        end
                    end else begin
                        state_d = S_HELD;
                    end
                end
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            div_q       <= '0;
            row_q       <= '0;
            row_drv_q   <= ~ROWS'(1);
            acc_n_q     <= 2'd0;
            acc_code_q  <= '0;
            fr_n_q      <= 2'd0;
            fr_code_q   <= '0;
            eval_q      <= 1'b0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            key_rel_q   <= 1'b0;
            key_down_q  <= 1'b0;
            multi_q     <= 1'b0;
        end else begin
            sync1_q     <= col_in;
            sync2_q     <= sync1_q;
            div_q       <= div_d;
            row_q       <= row_d;
            row_drv_q   <= row_drv_d;
            acc_n_q     <= acc_n_d;
            acc_code_q  <= acc_code_d;
            fr_n_q      <= fr_n_d;
            fr_code_q   <= fr_code_d;
            eval_q      <= eval_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            key_rel_q   <= key_rel_d;
            key_down_q  <= key_down_d;
            multi_q     <= multi_d;
        end
    end

    assign row_drv   = row_drv_q;
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign key_rel   = key_rel_q;
    assign key_down  = key_down_q;
    assign multi     = multi_q;

endmodule

// File: tb/tb_matrix_key_scanner.sv
// Bench for matrix_key_scanner: an ideal 4x4 key matrix driven frame by frame,
// checked every cycle against a frame-level run-length debounce model.
module tb_matrix_key_scanner;

    localparam int unsigned DEB = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  col_in;
    logic [3:0]  row_drv;
    logic [3:0]  key;
    logic        key_valid, key_rel, key_down, multi;
    logic [15:0] pressed = 16'h0000;

    int errors = 0;
    int checks = 0;

    // Model state: run lengths of identical frame results
    bit m_held = 0;
    int m_key = 0;
    int m_single_run = 0;
    int m_single_code = 0;
    int m_none_run = 0;
    bit m_multi = 0;
    bit m_valid = 0;
    bit m_rel = 0;

    matrix_key_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col_in    (col_in),
        .row_drv   (row_drv),
        .key       (key),
        .key_valid (key_valid),
        .key_rel   (key_rel),
        .key_down  (key_down),
        .multi     (multi)
    );

    always #5 clk = ~clk;

    // Ideal switch matrix: a pressed key pulls its column low while its row is driven
    always_comb begin
        col_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4 + c] && !row_drv[r]) col_in[c] = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_held = 0; m_key = 0; m_single_run = 0; m_single_code = 0;
        m_none_run = 0; m_multi = 0; m_valid = 0; m_rel = 0;
    endtask

    // Apply one frame's worth of key state to the model
    task automatic model_frame(input logic [15:0] k);
        int n;
        int code;
        n = $countones(k);
        code = 0;
        for (int i = 15; i >= 0; i--) if (k[i]) code = i;
        m_valid = 0;
        m_rel = 0;
        m_multi = (n >= 2);
        if (!m_held) begin
            if (n == 1) begin
                if (m_single_run > 0 && code == m_single_code) m_single_run++;
                else begin m_single_code = code; m_single_run = 1; end
                if (m_single_run >= DEB) begin
                    m_held = 1; m_key = code; m_valid = 1; m_none_run = 0;
                end
            end else begin
                m_single_run = 0;
            end
        end else begin
            if (n == 0) begin
                m_none_run++;
                if (m_none_run >= DEB) begin
                    m_held = 0; m_rel = 1; m_single_run = 0;
                end
            end else begin
                m_none_run = 0;
            end
        end
    endtask

    // Run one 16-cycle frame starting at row 0, dwell cycle 0, checking every cycle
    task automatic run_frame(input logic [15:0] k);
        logic [3:0] exp_row;
        pressed = k;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            exp_row = ~(4'b0001 << ((i / 4) % 4));
            check_eq("row_drv", 32'(row_drv), 32'(exp_row));
            if (i == 1) begin
                check_eq("key_valid", 32'(key_valid), 32'(m_valid));
                check_eq("key_rel", 32'(key_rel), 32'(m_rel));
            end else begin
                check_eq("key_valid_idle", 32'(key_valid), 32'd0);
                check_eq("key_rel_idle", 32'(key_rel), 32'd0);
            end
            check_eq("key_down", 32'(key_down), 32'(m_held));
            check_eq("key", 32'(key), 32'(m_key));
            check_eq("multi", 32'(multi), 32'(m_multi));
        end
        model_frame(k);
    endtask

    task automatic run_frames(input logic [15:0] k, input int n);
        for (int f = 0; f < n; f++) run_frame(k);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_row_drv"}, 32'(row_drv), 32'h0000000e);
        check_eq({tag, "_key"}, 32'(key), 32'd0);
        check_eq({tag, "_key_valid"}, 32'(key_valid), 32'd0);
        check_eq({tag, "_key_rel"}, 32'(key_rel), 32'd0);
        check_eq({tag, "_key_down"}, 32'(key_down), 32'd0);
        check_eq({tag, "_multi"}, 32'(multi), 32'd0);
    endtask

    // Pulse reset for one clock edge partway through a dwell, then realign to frame start
    task automatic reset_mid_frame();
        for (int i = 0; i < 6; i++) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        check_reset_values("rst_async");
        @(posedge clk); #1;
        check_reset_values("rst_held");
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [15:0] pat;
        int a, b, sel, len;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b1;

        // Idle scanning
        run_frames(16'h0000, 10);

        // Key 9 press, 1-frame glitch while held, then release
        run_frames(16'h0200, 4);
        check_eq("k9_code", 32'(key), 32'd9);
        check_eq("k9_down", 32'(key_down), 32'd1);
        run_frames(16'h0200, 1);
        run_frames(16'h0000, 1);
        run_frames(16'h0200, 2);
        check_eq("glitch_down", 32'(key_down), 32'd1);
        run_frames(16'h0000, 4);
        check_eq("k9_released", 32'(key_down), 32'd0);
        check_eq("k9_retained", 32'(key), 32'd9);

        // Bounce on key 3
        run_frames(16'h0008, 2);
        run_frames(16'h0000, 1);
        run_frames(16'h0008, 4);
        check_eq("k3_code", 32'(key), 32'd3);
        run_frames(16'h0000, 4);

        // Keys 5 and 10 together, then 10 released
        run_frames(16'h0420, 3);
        check_eq("multi_level", 32'(multi), 32'd1);
        check_eq("multi_no_accept", 32'(key_down), 32'd0);
        run_frames(16'h0020, 4);
        check_eq("k5_code", 32'(key), 32'd5);
        check_eq("k5_multi_clear", 32'(multi), 32'd0);
        run_frames(16'h0000, 4);

        // Reset while key 9 is held: needs full requalification
        pressed = 16'h0200;
        run_frames(16'h0200, 4);
        reset_mid_frame();
        run_frames(16'h0200, 4);
        check_eq("k9_after_reset", 32'(key), 32'd9);
        run_frames(16'h0000, 4);

        // Randomized patterns held for a few frames each
        for (int p = 0; p < 40; p++) begin
            sel = int'($urandom_range(0, 3));
            a = int'($urandom_range(0, 15));
            b = (a + 1 + int'($urandom_range(0, 14))) % 16;
            pat = 16'h0000;
            if (sel == 1 || sel == 2) pat[a] = 1'b1;
            else if (sel == 3) begin pat[a] = 1'b1; pat[b] = 1'b1; end
            len = int'($urandom_range(1, 5));
            run_frames(pat, len);
        end
        run_frames(16'h0000, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matrix_key_scanner.md
MATRIX_KEY_SCANNER -- requirements
Module: matrix_key_scanner

Interface
REQ-001 Parameter ROWS, default 4, number of driven rows; legal range 2..8.
REQ-002 Parameter COLS, default 4, number of sensed columns; legal range 2..8.
REQ-003 Parameter SCAN_DIV, default 4, clock cycles each row is driven; legal minimum 4.
REQ-004 Parameter DEBOUNCE, default 3, consecutive identical scan frames required to accept a press or release; legal range 1..255.
REQ-005 Derived KW = clog2(ROWS*COLS), with a minimum of 1.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 col_in  input  COLS  column sense lines, active-low (0 = pressed key on the driven row), asynchronous to clk.
REQ-009 row_drv  output  ROWS  row drive lines, one-cold (exactly one bit 0 at all times).
REQ-010 key  output  KW  code of the last accepted key.
REQ-011 key_valid  output  1  one-cycle pulse on press acceptance.
REQ-012 key_rel  output  1  one-cycle pulse on release acceptance.
REQ-013 key_down  output  1  level; high while an accepted key is held.
REQ-014 multi  output  1  level; high when the last completed frame saw two or more pressed keys.

Function
REQ-015 col_in SHALL pass through a 2-flop synchroniser before any use.
REQ-016 Row index SHALL advance every SCAN_DIV cycles, 0,1,..,ROWS-1, then wrap to 0; row_drv bit[index] = 0, all other bits 1.
REQ-017 The synchronised columns SHALL be sampled only in the last cycle of each row dwell.
REQ-018 Key code SHALL be row*COLS + col, where col is the index of a low column bit.
REQ-019 A frame is the ROWS consecutive dwells for rows 0..ROWS-1. The frame result is NONE, SINGLE(code) or MULTI (two or more low bits across the frame), and SHALL be evaluated in the cycle after row ROWS-1 is sampled.
REQ-020 multi SHALL update at each frame end: 1 if MULTI, else 0.
REQ-021 FSM states: IDLE, PRESS_CHK, HELD, REL_CHK; a debounce counter cnt and a candidate code cand.
REQ-022 IDLE: SINGLE(c) -> PRESS_CHK with cand=c and cnt=1; NONE or MULTI -> remain in IDLE.
REQ-023 PRESS_CHK: SINGLE(cand) -> cnt+1; SINGLE(c != cand) -> cand=c and cnt=1; NONE or MULTI -> IDLE.
REQ-024 In PRESS_CHK, when cnt reaches DEBOUNCE -> HELD, with key=cand, key_valid pulse and key_down=1 in the same cycle. With DEBOUNCE=1, the first SINGLE frame accepts immediately from IDLE.
REQ-025 HELD: NONE -> REL_CHK with cnt=1; SINGLE or MULTI -> remain in HELD. key SHALL not change, and no new key_valid SHALL occur.
REQ-026 REL_CHK: NONE -> cnt+1; any pressed key -> HELD.
REQ-027 In REL_CHK, when cnt reaches DEBOUNCE -> IDLE, with a key_rel pulse and key_down=0. key SHALL retain its value.
REQ-028 key_valid and key_rel SHALL never be high simultaneously and SHALL never be high for two consecutive cycles.
REQ-029 cnt SHALL saturate at DEBOUNCE and never wrap.
REQ-030 Latency: acceptance occurs at the frame-end evaluation of the DEBOUNCE-th matching frame; there is no further output delay.

Reset
REQ-031 rst low SHALL, asynchronously: set row index to 0 (row_drv = {1..1,0}), key=0, key_valid=0, key_rel=0, key_down=0, multi=0, FSM=IDLE, cnt=0, cand=0, dwell counter=0, synchroniser flops to all-ones, and clear the frame accumulator.
REQ-032 Reset asserted mid-press SHALL discard the press: no key_rel is issued, and after release of reset a held key requires a full DEBOUNCE qualification again.
REQ-033 Scanning SHALL restart from row 0 on the first clock edge after rst deasserts.

Verification (ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3; frame = 16 cycles)
REQ-034 No key pressed for 10 frames -> row_drv cycles 1110,1101,1011,0111 with 4 cycles each; key_valid, key_down and multi stay 0.
REQ-035 Hold row 2/col 1 (col_in=1101 while row_drv=1011) -> key=9, and a single key_valid pulse at the end of frame 3; key_down=1 until release, then key_rel at the end of the 3rd NONE frame.
REQ-036 Bounce: press row 0/col 3 for 2 frames, release 1 frame, press 3 frames -> exactly one key_valid, key=3, accepted at the end of the 3rd consecutive frame.
REQ-037 Press codes 5 and 10 together -> multi=1 from the first frame end; no key_valid. Then release code 10 -> key=5 accepted 3 frames later, with multi=0.
REQ-038 While key 9 is HELD, a 1-frame NONE glitch -> no key_rel; key_down stays 1.
REQ-039 Assert rst for 1 cycle mid-dwell while key 9 is held -> all outputs go to reset values immediately; key_valid is re-issued 3 frames after reset release.
